// File: rtl/conv_pool_layer_gen.sv
// KxK multi-channel valid convolution + ReLU + PxP max-pool + shift/quantise engine.
// Optional build macro CONV_SAT_EN clamps the shifted pool value to the positive O_BW range.
module conv_pool_layer_gen #(
  parameter int I_SIZE = 28,
  parameter int K_SIZE = 5,
  parameter int P_SIZE = 2,
  parameter int CI     = 1,
  parameter int CO     = 4,
  parameter int I_BW   = 8,
  parameter int W_BW   = 8,
  parameter int ACC_BW = 24,
  parameter int O_BW   = 16,
  parameter int SHIFT  = 4
) (
  input  logic                                    clk,
  input  logic                                    user_reset,
  input  logic                                    i_start,
  // valid/ready: a beat transfers on any rising edge where valid and ready are both high;
  // a producer holding valid keeps its data stable until that edge.
  input  logic signed [I_BW-1:0]                  i_data,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [CO*CI*K_SIZE*K_SIZE*W_BW-1:0]     i_weight,
  output logic signed [O_BW-1:0]                  o_data,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic                                    o_ch_end,
  output logic                                    o_all_end,
  output logic                                    o_busy,
  output logic [1:0]                              dbg_state
);

  localparam int C_SIZE = I_SIZE - K_SIZE + 1;
  localparam int Q_SIZE = C_SIZE / P_SIZE;
  localparam int DEPTH  = CI * I_SIZE * I_SIZE;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW     = CO * CI * K_SIZE * K_SIZE;
  localparam int WIW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int MACS   = P_SIZE * P_SIZE * CI * K_SIZE * K_SIZE;
  localparam int PW     = I_BW + W_BW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t state, next_state;

  int wr_cnt, step;
  int kx, ky, ci, dx, dy;
  int px, py, co;

  logic load_we, load_done, issue, compute_done;
  logic last_pt_ch, last_job, handshake;

  assign load_we      = (state == S_LOAD) && i_valid;
  assign load_done    = load_we && (wr_cnt == DEPTH - 1);
  assign issue        = (state == S_COMPUTE) && (step < MACS);
  assign compute_done = (state == S_COMPUTE) && (step == MACS + 1);
  assign last_pt_ch   = (px == Q_SIZE - 1) && (py == Q_SIZE - 1);
  assign last_job     = last_pt_ch && (co == CO - 1);
  assign handshake    = (state == S_OUTPUT) && i_ready;
  assign dbg_state    = state;

  // Feature-map buffer: one port shared by the loader and the MAC walker, read-first.
  logic signed [I_BW-1:0] mem [DEPTH];
  logic signed [I_BW-1:0] rd_data;
  logic [AW-1:0]          addr;
  int                     rd_addr_i;

  assign rd_addr_i = ci * I_SIZE * I_SIZE
                   + (py * P_SIZE + dy + ky) * I_SIZE
                   + (px * P_SIZE + dx + kx);
  assign addr = (state == S_LOAD) ? AW'(wr_cnt) : AW'(rd_addr_i);

  always_ff @(posedge clk) begin
    if (load_we) mem[addr] <= i_data;
    rd_data <= mem[addr];
  end

  logic signed [W_BW-1:0] w_arr [NW];
  int                     widx;

  for (genvar g = 0; g < NW; g++) begin : g_w
    assign w_arr[g] = i_weight[g*W_BW +: W_BW];
  end
  assign widx = ((co * CI + ci) * K_SIZE + ky) * K_SIZE + kx;

  always_ff @(posedge clk) begin
    if (user_reset) state <= S_IDLE;
    else            state <= next_state;
  end

  logic signed [O_BW-1:0] quant;

  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_busy     = 1'b0;
    o_ch_end   = 1'b0;
    o_all_end  = 1'b0;
    o_data     = '0;
    case (state)
      S_IDLE: begin
        if (i_start) next_state = S_LOAD;
      end
      S_LOAD: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (load_done) next_state = S_COMPUTE;
      end
      S_COMPUTE: begin
        o_busy = 1'b1;
        if (compute_done) next_state = S_OUTPUT;
      end
      S_OUTPUT: begin
        o_valid   = 1'b1;
        o_busy    = 1'b1;
        o_data    = quant;
        o_ch_end  = i_ready && last_pt_ch;
        o_all_end = i_ready && last_job;
        if (i_ready) next_state = last_job ? S_IDLE : S_COMPUTE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Counters: load address, per-point window walk (dy,dx,ci,ky,kx) and pooled coordinates.
  always_ff @(posedge clk) begin
    if (user_reset) begin
      wr_cnt <= 0;
      step   <= 0;
      kx     <= 0;
      ky     <= 0;
      ci     <= 0;
      dx     <= 0;
      dy     <= 0;
      px     <= 0;
      py     <= 0;
      co     <= 0;
    end else begin
      if (state == S_LOAD) begin
        if (i_valid) wr_cnt <= load_done ? 0 : wr_cnt + 1;
      end else begin
        wr_cnt <= 0;
      end

      if (state == S_COMPUTE) begin
        step <= step + 1;
        if (issue) begin
          if (kx == K_SIZE - 1) begin
            kx <= 0;
            if (ky == K_SIZE - 1) begin
              ky <= 0;
              if (ci == CI - 1) begin
                ci <= 0;
                if (dx == P_SIZE - 1) begin
                  dx <= 0;
                  dy <= (dy == P_SIZE - 1) ? 0 : dy + 1;
                end else begin
                  dx <= dx + 1;
                end
              end else begin
                ci <= ci + 1;
              end
            end else begin
              ky <= ky + 1;
            end
          end else begin
            kx <= kx + 1;
          end
        end
      end else begin
        step <= 0;
        kx   <= 0;
        ky   <= 0;
        ci   <= 0;
        dx   <= 0;
        dy   <= 0;
      end

      if (handshake) begin
        if (px == Q_SIZE - 1) begin
          px <= 0;
          if (py == Q_SIZE - 1) begin
            py <= 0;
            co <= (co == CO - 1) ? 0 : co + 1;
          end else begin
            py <= py + 1;
          end
        end else begin
          px <= px + 1;
        end
      end
    end
  end

  // MAC pipeline: stage 1 aligns the weight with the BRAM read, stage 2 folds the finished
  // conv point into the pool register.
  logic                     s1_valid, s1_first, s1_last, s2_last;
  logic signed [W_BW-1:0]   s1_w;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_BW-1:0] acc, pool, relu, shifted;

  assign prod    = PW'(rd_data) * PW'(s1_w);
  assign relu    = acc[ACC_BW-1] ? '0 : acc;
  assign shifted = pool >>> SHIFT;

  always_ff @(posedge clk) begin
    if (user_reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_w     <= '0;
      s2_last  <= 1'b0;
      acc      <= '0;
      pool     <= '0;
    end else begin
      s1_valid <= issue;
      s1_first <= (ci == 0) && (ky == 0) && (kx == 0);
      s1_last  <= (ci == CI - 1) && (ky == K_SIZE - 1) && (kx == K_SIZE - 1);
      s1_w     <= w_arr[WIW'(widx)];
      s2_last  <= s1_valid && s1_last;
      if (s1_valid) acc <= (s1_first ? '0 : acc) + ACC_BW'(prod);
      if ((state == S_COMPUTE) && (step == 0)) pool <= '0;
      else if (s2_last && (relu > pool))      pool <= relu;
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << (O_BW - 1)) - 1);
  assign quant = (shifted > SAT_MAX) ? O_BW'(SAT_MAX) : O_BW'(shifted);
`else
  assign quant = O_BW'(shifted);
`endif

endmodule

// File: tb/tb_conv_pool_layer_gen.sv
// Bench for conv_pool_layer_gen: directed plan cases plus random jobs against a
// window-arithmetic reference model; expectations follow CONV_SAT_EN like the design.
module tb_conv_pool_layer_gen;

  localparam int I      = 6;
  localparam int K      = 3;
  localparam int P      = 2;
  localparam int CI     = 2;
  localparam int CO     = 2;
  localparam int I_BW   = 8;
  localparam int W_BW   = 8;
  localparam int ACC_BW = 24;
  localparam int O_BW   = 8;
  localparam int SHIFT  = 0;
  localparam int C      = I - K + 1;
  localparam int Q      = C / P;
  localparam int NPIX   = CI * I * I;
  localparam int NW     = CO * CI * K * K;
  localparam int LAT    = P * P * CI * K * K + 2;

  logic                 clk, user_reset, i_start, i_valid, i_ready;
  logic [I_BW-1:0]      i_data;
  logic [NW*W_BW-1:0]   i_weight;
  logic [O_BW-1:0]      o_data;
  logic                 o_ready, o_valid, o_ch_end, o_all_end, o_busy;
  logic [1:0]           dbg_state;

  conv_pool_layer_gen #(
    .I_SIZE(I), .K_SIZE(K), .P_SIZE(P), .CI(CI), .CO(CO), .I_BW(I_BW),
    .W_BW(W_BW), .ACC_BW(ACC_BW), .O_BW(O_BW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .user_reset(user_reset), .i_start(i_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .i_weight(i_weight), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_ch_end(o_ch_end), .o_all_end(o_all_end),
    .o_busy(o_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [O_BW-1:0] exp_q[$];
  logic [1:0]      exp_end_q[$];   // [1] = all_end, [0] = ch_end

  int pix [CI][I][I];
  int wt  [CO][CI][K][K];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    user_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 user_reset = 1'b0;
  endtask

  task automatic fill_pix(input int ch, input int base, input int stp);
    for (int r = 0; r < I; r++)
      for (int c = 0; c < I; c++)
        pix[ch][r][c] = base + stp * (r * I + c);
  endtask

  task automatic fill_wt(input int o, input int ch, input int v);
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        wt[o][ch][ky][kx] = v;
  endtask

  task automatic push_ch(input int a, input int b, input int c, input int d, input bit last);
    exp_q.push_back(O_BW'(a)); exp_end_q.push_back(2'b00);
    exp_q.push_back(O_BW'(b)); exp_end_q.push_back(2'b00);
    exp_q.push_back(O_BW'(c)); exp_end_q.push_back(2'b00);
    exp_q.push_back(O_BW'(d)); exp_end_q.push_back({last, 1'b1});
  endtask

  // reference model: direct window sums, ReLU, max over pooling window, shift, quantise
  task automatic build_model();
    int best, s, sh, r, c;
    for (int o = 0; o < CO; o++)
      for (int qy = 0; qy < Q; qy++)
        for (int qx = 0; qx < Q; qx++) begin
          best = 0;
          for (int wy = 0; wy < P; wy++)
            for (int wx = 0; wx < P; wx++) begin
              r = qy * P + wy;
              c = qx * P + wx;
              s = 0;
              for (int ch = 0; ch < CI; ch++)
                for (int ky = 0; ky < K; ky++)
                  for (int kx = 0; kx < K; kx++)
                    s += pix[ch][r+ky][c+kx] * wt[o][ch][ky][kx];
              if (s < 0) s = 0;
              if (s > best) best = s;
            end
          sh = best >>> SHIFT;
`ifdef CONV_SAT_EN
          if (sh > (1 << (O_BW - 1)) - 1) sh = (1 << (O_BW - 1)) - 1;
`else
          sh = sh & ((1 << O_BW) - 1);
`endif
          exp_q.push_back(O_BW'(sh));
          exp_end_q.push_back({(o == CO - 1) && (qy == Q - 1) && (qx == Q - 1),
                               (qy == Q - 1) && (qx == Q - 1)});
        end
  endtask

  // driver: weights, start pulse and pixel stream (optional idle gaps / stray start)
  task automatic load_image(input bit gaps, input bit glitch);
    int ch, r, c;
    for (int o = 0; o < CO; o++)
      for (int ch2 = 0; ch2 < CI; ch2++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            i_weight[(((o*CI+ch2)*K+ky)*K+kx)*W_BW +: W_BW] = W_BW'(wt[o][ch2][ky][kx]);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    check_eq("load_ready", o_ready, 1);
    check_eq("load_busy", o_busy, 1);
    check_eq("load_state", dbg_state, 1);
    for (int idx = 0; idx < NPIX; idx++) begin
      ch = idx / (I * I);
      r  = (idx / I) % I;
      c  = idx % I;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        i_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_valid = 1'b1;
      i_data  = I_BW'(pix[ch][r][c]);
      i_start = glitch && (idx == 10);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check_eq("ready_drop", o_ready, 0);
    check_eq("compute_state", dbg_state, 2);
  endtask

  task automatic wait_first();
    int lat = 0;
    while (!o_valid && lat < 2000) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check_eq("first_latency", lat, LAT);
  endtask

  // scoreboard: mode 0 always ready, 1 random ready, 2 stall beat 2 for 5 cycles
  task automatic collect(input int mode);
    int beat = 0, stall = 0, guard = 0;
    logic held = 1'b0;
    logic [O_BW-1:0] last_d = '0;
    logic [O_BW-1:0] e;
    logic [1:0] f;
    while (exp_q.size() > 0 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      case (mode)
        0: i_ready = 1'b1;
        1: i_ready = 1'($urandom_range(0, 1));
        default: begin
          if (beat == 1 && stall < 5 && o_valid) begin
            i_ready = 1'b0;
            stall++;
          end else begin
            i_ready = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      if (held) begin
        check_eq("hold_valid", o_valid, 1);
        check_eq("hold_data", o_data, last_d);
      end
      if (o_valid && i_ready) begin
        e = exp_q.pop_front();
        f = exp_end_q.pop_front();
        check_eq($sformatf("beat%0d_data", beat), o_data, e);
        check_eq($sformatf("beat%0d_ch_end", beat), o_ch_end, f[0]);
        check_eq($sformatf("beat%0d_all_end", beat), o_all_end, f[1]);
        beat++;
        held = 1'b0;
      end else begin
        held   = o_valid;
        last_d = o_data;
      end
    end
    check_eq("beats_left", exp_q.size(), 0);
    exp_q.delete();
    exp_end_q.delete();
    @(posedge clk); #1 i_ready = 1'b0;
    @(negedge clk);
    check_eq("end_busy", o_busy, 0);
    check_eq("end_valid", o_valid, 0);
    check_eq("end_state", dbg_state, 0);
  endtask

  task automatic setup_t1();
    fill_pix(0, 1, 0);
    fill_pix(1, 0, 0);
    for (int o = 0; o < CO; o++)
      for (int ch = 0; ch < CI; ch++) fill_wt(o, ch, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, o_ready, 0);
    check_eq({tag, "_valid"}, o_valid, 0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_ch_end"}, o_ch_end, 0);
    check_eq({tag, "_all_end"}, o_all_end, 0);
    check_eq({tag, "_data"}, o_data, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    user_reset = 1'b0;
    i_start    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_data     = '0;
    i_weight   = '0;
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");

    // all-ones image and weights
    setup_t1();
    push_ch(9, 9, 9, 9, 0); push_ch(9, 9, 9, 9, 1);
    load_image(0, 0); wait_first(); collect(0);

    // negative weights: ReLU floors everything
    for (int o = 0; o < CO; o++)
      for (int ch = 0; ch < CI; ch++) fill_wt(o, ch, -1);
    push_ch(0, 0, 0, 0, 0); push_ch(0, 0, 0, 0, 1);
    load_image(0, 0); wait_first(); collect(0);

    // ramp image, centre tap only
    fill_pix(0, 0, 1);
    for (int o = 0; o < CO; o++) begin
      for (int ch = 0; ch < CI; ch++) fill_wt(o, ch, 0);
      wt[o][0][1][1] = 1;
    end
    push_ch(14, 16, 26, 28, 0); push_ch(14, 16, 26, 28, 1);
    load_image(0, 0); wait_first(); collect(0);

    // back-pressure on beat 2
    setup_t1();
    push_ch(9, 9, 9, 9, 0); push_ch(9, 9, 9, 9, 1);
    load_image(0, 0); wait_first(); collect(2);

    // two input channels, two output channels
    fill_pix(0, 1, 0); fill_pix(1, 2, 0);
    fill_wt(0, 0, 1); fill_wt(0, 1, 1); fill_wt(1, 0, 2); fill_wt(1, 1, 2);
    push_ch(27, 27, 27, 27, 0); push_ch(54, 54, 54, 54, 1);
    load_image(0, 0); wait_first(); collect(0);

    // large sums: saturate or truncate to 8 bits
    fill_pix(0, 127, 0); fill_pix(1, 0, 0);
    fill_wt(0, 0, 127); fill_wt(0, 1, 0); fill_wt(1, 0, 127); fill_wt(1, 1, 0);
`ifdef CONV_SAT_EN
    push_ch(127, 127, 127, 127, 0); push_ch(127, 127, 127, 127, 1);
`else
    push_ch(9, 9, 9, 9, 0); push_ch(9, 9, 9, 9, 1);
`endif
    load_image(0, 0); wait_first(); collect(0);

    // abort during compute, then rerun with a stray start inside the load
    setup_t1();
    load_image(0, 0);
    repeat (20) @(posedge clk);
    #1 user_reset = 1'b1;
    @(posedge clk); #1 user_reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    push_ch(9, 9, 9, 9, 0); push_ch(9, 9, 9, 9, 1);
    load_image(0, 1); wait_first(); collect(0);

    // random jobs against the model
    for (int job = 0; job < 4; job++) begin
      for (int ch = 0; ch < CI; ch++)
        for (int r = 0; r < I; r++)
          for (int c = 0; c < I; c++)
            pix[ch][r][c] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < CO; o++)
        for (int ch = 0; ch < CI; ch++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              wt[o][ch][ky][kx] = int'($urandom_range(0, 255)) - 128;
      build_model();
      load_image(1, 0); wait_first(); collect(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
